demux_8_buf: RTL and testbench

- 1-to-2 demultiplexer for 8-bit datapath words; the inverse of the 2-to-1 8-bit select mux used throughout the CPU datapath.
- Routes one incoming word per cycle to output A or B by `sel`.
- Each output has its own small FIFO with a valid/ready handshake, so a stalled consumer on one side never corrupts or reorders the other.
- Sits between the ALU/memory result bus and two downstream consumers: the register-file write port and the output/IO port.

---
 rtl/demux_8_buf.sv | 138 +++++++++++++
 tb/tb_demux_8_buf.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/demux_8_buf.sv
// 1-to-2 word demux into two independent valid/ready FIFOs; push-to-head latency is 1 cycle, with no bypass.
// Backpressure: in_ready drops only when the FIFO addressed by sel is full; each side drains on its own x_ready.

module demux_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  output logic                     full,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [WIDTH-1:0]         out_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count_nxt;
  logic [WIDTH-1:0]   hold_dat;
  logic               push, pop;

  assign full    = (state == FULL);
  assign out_vld = (count != '0);
  assign push    = push_vld && !full;
  assign pop     = out_vld && out_rdy;
  // Once empty, show the last head word rather than whatever stale slot rd_ptr now points at.
  assign out_dat = out_vld ? mem[rd_ptr] : hold_dat;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (push) state_nxt = PARTIAL;
      PARTIAL: begin
        if (push && !pop && count == LAST)     state_nxt = FULL;
        else if (pop && !push && count == ONE) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = PARTIAL;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      hold_dat <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (out_vld) hold_dat <= mem[rd_ptr];
      count <= count_nxt;
    end
  end
endmodule

module demux_8_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   sel,
  output logic                   a_valid,
  input  logic                   a_ready,
  output logic [WIDTH-1:0]       a_data,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [WIDTH-1:0]       b_data,
  output logic [$clog2(DEPTH):0] a_count,
  output logic [$clog2(DEPTH):0] b_count
);
  logic a_full, b_full;
  logic a_push, b_push;

  // Depends only on sel and FIFO occupancy, so a same-cycle pop never frees a slot for the push.
  assign in_ready = sel ? !b_full : !a_full;
  assign a_push   = in_valid && in_ready && !sel;
  assign b_push   = in_valid && in_ready &&  sel;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (a_push),
    .push_dat (in_data),
    .full     (a_full),
    .out_vld  (a_valid),
    .out_rdy  (a_ready),
    .out_dat  (a_data),
    .count    (a_count)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (b_push),
    .push_dat (in_data),
    .full     (b_full),
    .out_vld  (b_valid),
    .out_rdy  (b_ready),
    .out_dat  (b_data),
    .count    (b_count)
  );
endmodule

// File: tb/tb_demux_8_buf.sv
// Directed bench for demux_8_buf: push/pop ordering, full backpressure, pointer wrap and async reset.
module tb_demux_8_buf;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_ready, sel;
  logic [7:0] in_data;
  logic       a_valid, a_ready, b_valid, b_ready;
  logic [7:0] a_data, b_data;
  logic [1:0] a_count, b_count;

  int checks = 0;
  int fails  = 0;

  demux_8_buf #(.WIDTH(8), .DEPTH(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .sel      (sel),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_data   (b_data),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; sel = 1'b0; in_data = 8'h00;
    a_ready = 1'b0; b_ready = 1'b0;
    #1;
    check("rst_a_valid", a_valid, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_a_data", a_data, 0);
    check("rst_b_data", b_data, 0);
    check("rst_a_count", a_count, 0);
    check("rst_b_count", b_count, 0);
    check("rst_in_ready", in_ready, 1);
    #11 reset_n = 1'b1;

    // 1: single push to A
    in_valid = 1'b1; sel = 1'b0; in_data = 8'h3C;
    #1 check("t1_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("t1_a_valid", a_valid, 1);
    check("t1_a_data", a_data, 8'h3C);
    check("t1_a_count", a_count, 1);
    check("t1_b_valid", b_valid, 0);
    check("t1_b_count", b_count, 0);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    check("t1_a_drained", a_valid, 0);
    check("t1_a_hold", a_data, 8'h3C);

    // 2/3: fill B, backpressure, pop and push in the full cycle
    in_valid = 1'b1; sel = 1'b1; in_data = 8'h11;
    tick();
    check("t2_b_count1", b_count, 1);
    in_data = 8'h22;
    tick();
    check("t2_b_count2", b_count, 2);
    check("t2_b_head", b_data, 8'h11);
    in_valid = 1'b0; sel = 1'b0;
    #1 check("t2_ready_sel0", in_ready, 1);
    sel = 1'b1; in_valid = 1'b1; in_data = 8'h33;
    #1 check("t2_ready_sel1", in_ready, 0);
    tick();
    check("t2_held_count", b_count, 2);
    check("t2_held_head", b_data, 8'h11);
    b_ready = 1'b1;
    #1 check("t3_no_pop_through", in_ready, 0);
    tick();
    check("t3_pop_count", b_count, 1);
    check("t3_pop_head", b_data, 8'h22);
    check("t3_ready_again", in_ready, 1);
    b_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("t3_push_count", b_count, 2);
    b_ready = 1'b1;
    check("t2_order0", b_data, 8'h22);
    tick();
    check("t2_order1", b_data, 8'h33);
    check("t2_order1_cnt", b_count, 1);
    tick();
    b_ready = 1'b0;
    check("t2_b_empty", b_valid, 0);
    check("t2_b_count0", b_count, 0);

    // 4: simultaneous push/pop on A, then pointer wrap
    in_valid = 1'b1; sel = 1'b0; in_data = 8'h5A;
    tick();
    check("t4_pre_count", a_count, 1);
    in_data = 8'hA5; a_ready = 1'b1;
    tick();
    check("t4_pp_count", a_count, 1);
    check("t4_pp_data", a_data, 8'hA5);
    for (int i = 0; i < 6; i++) begin
      in_data = 8'h60 + 8'(i);
      tick();
      check("t4_wrap_data", a_data, 8'h60 + 8'(i));
      check("t4_wrap_count", a_count, 1);
    end
    in_valid = 1'b0;
    tick();
    a_ready = 1'b0;
    check("t4_a_empty", a_count, 0);

    // 5: interleaved sel with both consumers ready
    a_ready = 1'b1; b_ready = 1'b1; in_valid = 1'b1;
    sel = 1'b0; in_data = 8'h01;
    tick();
    check("t5_a01", a_data, 8'h01);
    check("t5_a01_vld", a_valid, 1);
    check("t5_b_idle", b_valid, 0);
    sel = 1'b1; in_data = 8'h02;
    tick();
    check("t5_b02", b_data, 8'h02);
    check("t5_b02_vld", b_valid, 1);
    check("t5_a_gone", a_valid, 0);
    sel = 1'b0; in_data = 8'h03;
    tick();
    check("t5_a03", a_data, 8'h03);
    check("t5_a03_vld", a_valid, 1);
    check("t5_b_gone", b_valid, 0);
    sel = 1'b1; in_data = 8'h04;
    tick();
    check("t5_b04", b_data, 8'h04);
    check("t5_b04_vld", b_valid, 1);
    in_valid = 1'b0;
    tick();
    check("t5_a_end", a_count, 0);
    check("t5_b_end", b_count, 0);

    // 6: async reset with buffered words
    a_ready = 1'b0; b_ready = 1'b0; in_valid = 1'b1;
    sel = 1'b0; in_data = 8'h71;
    tick();
    in_data = 8'h72;
    tick();
    sel = 1'b1; in_data = 8'h81;
    tick();
    in_valid = 1'b0;
    check("t6_pre_a", a_count, 2);
    check("t6_pre_b", b_count, 1);
    #3 reset_n = 1'b0;
    #1;
    check("t6_a_valid", a_valid, 0);
    check("t6_b_valid", b_valid, 0);
    check("t6_a_data", a_data, 0);
    check("t6_b_data", b_data, 0);
    check("t6_a_count", a_count, 0);
    check("t6_b_count", b_count, 0);
    check("t6_in_ready", in_ready, 1);
    #2 reset_n = 1'b1;
    a_ready = 1'b1;
    tick();
    tick();
    check("t6_post_valid", a_valid, 0);
    check("t6_post_count", a_count, 0);
    check("t6_post_data", a_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
